// File: rtl/alu_pkg.sv
// Shared definitions for the accumulator stage: datapath width, command
// encodings and controller states.
package alu_pkg;

   localparam int ALU_WIDTH = 4;

   typedef enum logic [1:0] {
      OP_LOAD = 2'b00,
      OP_ADD  = 2'b01,
      OP_SUB  = 2'b10,
      OP_MUL  = 2'b11
   } op_t;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_MUL  = 1'b1
   } state_t;

endpackage

// File: rtl/alu_accumulator_if.sv
// Command/result bundle between an upstream command source (master) and the
// accumulator stage (slave).
interface alu_accumulator_if;
   import alu_pkg::*;

   logic                 in_valid;
   logic                 in_ready;
   logic [1:0]           op;
   logic [ALU_WIDTH-1:0] operand;
   logic [ALU_WIDTH-1:0] acc;
   logic                 carry;
   logic                 overflow;
   logic                 ovf_sticky;
   logic                 out_valid;
   logic                 busy;

   modport master (
      output in_valid, op, operand,
      input  in_ready, acc, carry, overflow, ovf_sticky, out_valid, busy
   );

   modport slave (
      input  in_valid, op, operand,
      output in_ready, acc, carry, overflow, ovf_sticky, out_valid, busy
   );

endinterface

// File: rtl/adder.sv
// Ripple-carry add/subtract: m=1 inverts b and injects a carry-in, giving a-b.
// c_out is the unsigned carry (no-borrow for subtract); overflow is signed.
module adder
   import alu_pkg::*;
#(
   parameter int WIDTH = ALU_WIDTH
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             m,
   output logic [WIDTH-1:0] sum,
   output logic             c_out,
   output logic             overflow
);

   logic [WIDTH-1:0] b_eff;
   logic [WIDTH:0]   carry_chain;

   assign b_eff          = b ^ {WIDTH{m}};
   assign carry_chain[0] = m;

   for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
      assign sum[gi]           = a[gi] ^ b_eff[gi] ^ carry_chain[gi];
      assign carry_chain[gi+1] = (a[gi] & b_eff[gi]) | (carry_chain[gi] & (a[gi] ^ b_eff[gi]));
   end

   assign c_out    = carry_chain[WIDTH];
   // Signed overflow: carry into the sign bit differs from carry out of it.
   assign overflow = carry_chain[WIDTH] ^ carry_chain[WIDTH-1];

endmodule

// File: rtl/alu_accumulator.sv
// Accumulator stage with LOAD/ADD/SUB in one cycle and MUL as repeated
// addition through a single shared adder, sequenced by a two-state controller.
module alu_accumulator
   import alu_pkg::*;
#(
   parameter int WIDTH = ALU_WIDTH
) (
   input  logic              clk,
   input  logic              rst_n,
   alu_accumulator_if.slave  bus
);

   state_t           state_q;
   logic [WIDTH-1:0] acc_q;
   logic [WIDTH-1:0] mcand_q;
   logic [WIDTH-1:0] partial_q;
   logic [WIDTH-1:0] count_q;
   logic             carry_q;
   logic             overflow_q;
   logic             sticky_q;
   logic             out_valid_q;
   logic             mcarry_q;

   logic [WIDTH-1:0] add_a;
   logic [WIDTH-1:0] add_b;
   logic [WIDTH-1:0] add_sum;
   logic             add_m;
   logic             add_c;
   logic             add_v;
   logic             accept;
   logic             mul_lost;
   op_t              op_in;

   assign op_in    = op_t'(bus.op);
   assign accept   = bus.in_valid && (state_q == ST_IDLE);
   assign mul_lost = mcarry_q | add_c;

   // The adder serves the accumulator while idle and the partial product during MUL.
   always_comb begin
      add_a = acc_q;
      add_b = bus.operand;
      add_m = (op_in == OP_SUB);
      if (state_q == ST_MUL) begin
         add_a = partial_q;
         add_b = mcand_q;
         add_m = 1'b0;
      end
   end

   adder #(.WIDTH(WIDTH)) u_adder (
      .a        (add_a),
      .b        (add_b),
      .m        (add_m),
      .sum      (add_sum),
      .c_out    (add_c),
      .overflow (add_v)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         acc_q       <= '0;
         mcand_q     <= '0;
         partial_q   <= '0;
         count_q     <= '0;
         carry_q     <= 1'b0;
         overflow_q  <= 1'b0;
         sticky_q    <= 1'b0;
         out_valid_q <= 1'b0;
         mcarry_q    <= 1'b0;
      end else begin
         out_valid_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (accept) begin
                  case (op_in)
                     OP_LOAD: begin
                        acc_q       <= bus.operand;
                        carry_q     <= 1'b0;
                        overflow_q  <= 1'b0;
                        sticky_q    <= 1'b0;
                        out_valid_q <= 1'b1;
                     end
                     OP_ADD, OP_SUB: begin
                        acc_q       <= add_sum;
                        carry_q     <= add_c;
                        overflow_q  <= add_v;
                        sticky_q    <= sticky_q | add_v;
                        out_valid_q <= 1'b1;
                     end
                     OP_MUL: begin
                        mcand_q   <= acc_q;
                        count_q   <= bus.operand;
                        partial_q <= '0;
                        mcarry_q  <= 1'b0;
                        if (bus.operand == '0) begin
                           acc_q       <= '0;
                           carry_q     <= 1'b0;
                           overflow_q  <= 1'b0;
                           out_valid_q <= 1'b1;
                        end else begin
                           state_q <= ST_MUL;
                        end
                     end
                     default: ;
                  endcase
               end
            end
            ST_MUL: begin
               partial_q <= add_sum;
               mcarry_q  <= mul_lost;
               count_q   <= count_q - WIDTH'(1);
               if (count_q == WIDTH'(1)) begin
                  acc_q       <= add_sum;
                  carry_q     <= mul_lost;
                  overflow_q  <= mul_lost;
                  sticky_q    <= sticky_q | mul_lost;
                  out_valid_q <= 1'b1;
                  state_q     <= ST_IDLE;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign bus.in_ready   = (state_q == ST_IDLE);
   assign bus.busy       = (state_q != ST_IDLE);
   assign bus.acc        = acc_q;
   assign bus.carry      = carry_q;
   assign bus.overflow   = overflow_q;
   assign bus.ovf_sticky = sticky_q;
   assign bus.out_valid  = out_valid_q;

endmodule

// File: tb/tb_alu_accumulator.sv
// Scoreboard bench: the driver pushes reference-model results at each accept,
// a negedge monitor pops and compares whenever out_valid is seen.
module tb_alu_accumulator;

   localparam logic [1:0] LD = 2'b00;
   localparam logic [1:0] AD = 2'b01;
   localparam logic [1:0] SB = 2'b10;
   localparam logic [1:0] ML = 2'b11;

   typedef struct {
      int acc;
      int c;
      int v;
      int s;
      int cyc;
   } exp_t;

   logic clk;
   logic rst_n;
   int   cyc;
   int   total;
   int   passed;
   int   m_acc;
   int   m_sticky;
   exp_t sb_q[$];

   alu_accumulator_if bus ();

   alu_accumulator dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input int act, input int req);
      total++;
      if (act == req) passed++;
      else $display("FAIL %s: got %0d, required %0d", name, act, req);
   endtask

   function automatic int sgn4(input int x);
      return (x >= 8) ? x - 16 : x;
   endfunction

   // Reference model: plain integer arithmetic on the architectural result.
   task automatic model(input logic [1:0] o, input int n, output exp_t e);
      int r;
      int sr;
      e.c = 0;
      e.v = 0;
      case (o)
         LD: begin
            m_acc    = n;
            m_sticky = 0;
         end
         AD: begin
            r     = m_acc + n;
            sr    = sgn4(m_acc) + sgn4(n);
            e.c   = (r > 15) ? 1 : 0;
            e.v   = (sr > 7 || sr < -8) ? 1 : 0;
            m_acc = r % 16;
         end
         SB: begin
            sr    = sgn4(m_acc) - sgn4(n);
            e.c   = (m_acc >= n) ? 1 : 0;
            e.v   = (sr > 7 || sr < -8) ? 1 : 0;
            m_acc = (m_acc + 16 - n) % 16;
         end
         default: begin
            r     = m_acc * n;
            e.c   = (r > 15) ? 1 : 0;
            e.v   = e.c;
            m_acc = r % 16;
         end
      endcase
      if (e.v != 0) m_sticky = 1;
      e.acc = m_acc;
      e.s   = m_sticky;
      e.cyc = cyc + 1 + ((o == ML) ? n : 0);
   endtask

   // Called at #1 after a rising edge; holds the command until accepted.
   task automatic send(input logic [1:0] o, input int n, input int exp_wait);
      int   w;
      bit   timed_out;
      exp_t e;
      w         = 0;
      timed_out = 0;
      bus.in_valid = 1'b1;
      bus.op       = o;
      bus.operand  = 4'(n);
      while (!bus.in_ready) begin
         @(posedge clk); #1;
         w++;
         if (w > 40) begin
            timed_out = 1;
            break;
         end
      end
      check("accept_wait_bound", int'(timed_out), 0);
      if (exp_wait >= 0) check("busy_cycles", w, exp_wait);
      model(o, n, e);
      sb_q.push_back(e);
      $display("cmd op=%0d operand=%0d waited=%0d expect acc=%0d c=%0d v=%0d s=%0d",
               o, n, w, e.acc, e.c, e.v, e.s);
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
   endtask

   task automatic settle();
      int w;
      w = 0;
      while (!bus.in_ready && w < 40) begin
         @(posedge clk); #1;
         w++;
      end
      check("settle_bound", int'(bus.in_ready), 1);
      @(posedge clk); #1;
   endtask

   task automatic check_flags(input string tag, input int a, input int c, input int v, input int s);
      check({tag, "_acc"}, int'(bus.acc), a);
      check({tag, "_carry"}, int'(bus.carry), c);
      check({tag, "_ovf"}, int'(bus.overflow), v);
      check({tag, "_sticky"}, int'(bus.ovf_sticky), s);
   endtask

   always @(negedge clk) begin
      if (rst_n && bus.out_valid) begin
         if (sb_q.size() == 0) begin
            check("unexpected_out_valid", 1, 0);
         end else begin
            exp_t e;
            e = sb_q.pop_front();
            check("sb_acc", int'(bus.acc), e.acc);
            check("sb_carry", int'(bus.carry), e.c);
            check("sb_ovf", int'(bus.overflow), e.v);
            check("sb_sticky", int'(bus.ovf_sticky), e.s);
            check("sb_latency", cyc, e.cyc);
         end
      end
   end

   initial begin
      total        = 0;
      passed       = 0;
      m_acc        = 0;
      m_sticky     = 0;
      rst_n        = 1'b0;
      bus.in_valid = 1'b0;
      bus.op       = 2'b00;
      bus.operand  = 4'd0;
      repeat (2) @(posedge clk);
      #1;
      check_flags("reset", 0, 0, 0, 0);
      check("reset_out_valid", int'(bus.out_valid), 0);
      check("reset_in_ready", int'(bus.in_ready), 1);
      check("reset_busy", int'(bus.busy), 0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      send(LD, 3, 0); send(AD, 5, 0); settle();
      check_flags("add_3_5", 8, 0, 1, 1);

      send(LD, 7, 0); send(SB, 1, 0); settle();
      check_flags("sub_7_1", 6, 1, 0, 0);
      send(LD, 8, 0); send(SB, 1, 0); settle();
      check_flags("sub_8_1", 7, 1, 1, 1);
      send(LD, 4, 0); settle();
      check_flags("load_clears", 4, 0, 0, 0);

      // ADD held on the bus while MUL 5 runs: accepted only once idle again.
      send(LD, 3, 0); send(ML, 5, 0); send(AD, 0, 5); settle();
      check_flags("mul_3_5", 15, 0, 0, 0);
      send(LD, 6, 0); send(ML, 3, 0); settle();
      check_flags("mul_6_3", 2, 1, 1, 1);

      send(LD, 9, 0); send(ML, 0, 0);
      check("mul0_busy", int'(bus.busy), 0);
      send(AD, 0, 0); settle();
      check_flags("mul_9_0", 0, 0, 0, 0);

      // Abort a multiply with reset after two MUL cycles.
      send(LD, 5, 0); settle(); send(ML, 4, 0);
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      check_flags("abort", 0, 0, 0, 0);
      check("abort_out_valid", int'(bus.out_valid), 0);
      check("abort_in_ready", int'(bus.in_ready), 1);
      sb_q.delete();
      m_acc    = 0;
      m_sticky = 0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      check("abort_no_pulse", int'(bus.out_valid), 0);
      send(LD, 2, 0); settle();
      check_flags("after_abort", 2, 0, 0, 0);

      for (int i = 0; i < 80; i++) begin
         logic [1:0] o;
         int         n;
         o = 2'($urandom_range(0, 3));
         n = (o == ML) ? int'($urandom_range(0, 6)) : int'($urandom_range(0, 15));
         send(o, n, -1);
         repeat ($urandom_range(0, 2)) begin
            @(posedge clk); #1;
         end
      end
      settle();
      check("scoreboard_drained", sb_q.size(), 0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/alu_accumulator.md
# alu_accumulator

Registered accumulator stage that sits directly downstream of the team's 4-bit `adder` (add/subtract with carry and signed-overflow outputs) and drives it. It accepts one command per handshake (load, add, subtract, multiply) and holds the 4-bit result in an accumulator register with registered carry, overflow and sticky-overflow flags. Multiply is multi-cycle repeated addition through the same adder instance, under a small FSM.

## Interface
Parameters:
- WIDTH, 4, datapath width; fixed at 4 to match `adder`; other values unsupported.

Ports:
- clk  in  1  rising-edge clock; the only clock.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  command present.
- in_ready  out  1  block can accept a command; high iff FSM in IDLE.
- op  in  2  00 LOAD, 01 ADD, 10 SUB, 11 MUL.
- operand  in  WIDTH  command operand.
- acc  out  WIDTH  accumulator value.
- carry  out  1  carry flag of last completed command.
- overflow  out  1  overflow flag of last completed command.
- ovf_sticky  out  1  set by any completed command with overflow=1.
- out_valid  out  1  one-cycle pulse after a command completes.
- busy  out  1  equals !in_ready.

## Operation
- Accept: in_valid && in_ready at a rising edge. No accept while busy; in_valid is ignored then, and the upstream holds the command.
- LOAD: acc <= operand, carry <= 0, overflow <= 0, ovf_sticky <= 0.
- ADD: acc <= acc + operand via `adder` with m=0; carry <= c_out, overflow <= adder signed overflow.
- SUB: acc <= acc - operand via `adder` with m=1 (two's complement); carry <= c_out (1 = no borrow); overflow <= adder overflow.
- MUL: unsigned acc*operand mod 16.
  - At accept: mcand <= acc, count <= operand, partial <= 0, mcarry <= 0.
  - operand == 0: acc <= 0, carry <= 0, overflow <= 0, out_valid next cycle, stay IDLE.
  - Otherwise enter MUL. Each cycle: partial <= partial + mcand via `adder` (m=0); mcarry |= c_out; count--.
  - On the cycle count==1: acc <= final sum, carry <= overflow <= mcarry | c_out (unsigned product exceeded 4 bits); return to IDLE.
- ovf_sticky: set whenever a completion registers overflow=1. Cleared only by LOAD or reset.
- The adder is shared. In IDLE, a = acc, b = operand, m = (op==SUB). In MUL, a = partial, b = mcand, m = 0.
- FSM states: IDLE, MUL. Transitions: IDLE->MUL on accepted MUL with operand != 0. MUL->IDLE when count==1. Reset forces IDLE from any state.

## Timing
- Reset (asynchronous, while rst_n=0): acc=0, carry=0, overflow=0, ovf_sticky=0, out_valid=0, FSM=IDLE. Therefore in_ready=1 and busy=0 during and after reset.
- LOAD/ADD/SUB: result registered at the accept edge. out_valid is high for exactly the following cycle, and acc is valid then. Back-to-back accepts are allowed every cycle.
- MUL with operand n >= 1: acc updates n edges after the accept edge. in_ready=0 for those n cycles. out_valid pulses in the cycle after the final edge, which is the same cycle in_ready returns to 1. A new command may be accepted in that cycle.
- MUL with n=0: 1-cycle latency, identical to ADD.
- acc, carry and overflow hold their values between completions. During MUL they keep their pre-MUL values until the final edge.
- Reset asserted mid-MUL aborts the command: no out_valid, acc=0.
- Wrap-around: all arithmetic is modulo 2^WIDTH. Flags report the loss.

## Structure
- Package `alu_pkg`: op encodings (OP_LOAD, OP_ADD, OP_SUB, OP_MUL), state enum (ST_IDLE, ST_MUL), WIDTH constant.
- One sub-module: the existing `adder` (a, b, m, sum, c_out, overflow), instantiated once and muxed as described above. All other logic is inline: the FSM, count/mcand/partial registers, and the flag registers.

## Test plan
- Reset with rst_n=0 mid-stream -> acc=0, carry=0, overflow=0, ovf_sticky=0, out_valid=0, in_ready=1.
- LOAD 3, then ADD 5 -> acc=8, carry=0, overflow=1, ovf_sticky=1, out_valid one cycle per command. Back-to-back accepts with no bubble.
- LOAD 7, then SUB 1 -> acc=6, carry=1, overflow=0. Then LOAD 8, SUB 1 -> acc=7, carry=1, overflow=1, ovf_sticky=1. The next LOAD clears ovf_sticky.
- LOAD 3, then MUL 5 with in_valid held high and op=ADD queued -> in_ready low 5 cycles, acc=15, carry=0, overflow=0. The queued ADD is accepted only in the out_valid cycle. LOAD 6, MUL 3 -> acc=2, carry=1, overflow=1.
- LOAD 9, then MUL 0 -> acc=0, flags 0, 1-cycle latency, no busy.
- LOAD 5, MUL 4, then pulse rst_n low after 2 MUL cycles -> acc=0 immediately, no out_valid, in_ready=1. A following LOAD 2 works normally.
